exp_idx_sel_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational range-index selector in the exponent datapath.
- Compares the low CMP_W bits of an operand against a descending table of programmable thresholds and returns a 1-based range index: the smallest j+1 with operand > th[j], or NUM_TH+1 if no threshold is exceeded.
- Sits between operand staging and the range-reduction LUT, using valid/ready handshakes on both sides.
- The threshold table can be reprogrammed at run time through a small config port.

---
 rtl/exp_idx_sel_pipe_pkg.sv | 28 ++
 rtl/exp_idx_sel_pipe_if.sv | 39 +++
 rtl/exp_idx_sel_pipe_penc.sv | 17 +
 rtl/exp_idx_sel_pipe.sv | 162 ++++++++++++++++
 tb/tb_exp_idx_sel_pipe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/exp_idx_sel_pipe_pkg.sv
// Shared constants for the exponent range-index selector: default threshold
// table, reset-value helper and the reserved above-range index code.
package exp_sel_pkg;

  localparam int NUM_TH_DEF = 10;
  localparam int CMP_W_DEF  = 11;

  localparam logic [31:0] TH_DEFAULT [NUM_TH_DEF] =
    '{32'd830, 32'd456, 32'd241, 32'd124, 32'd63,
      32'd31,  32'd15,  32'd7,   32'd3,   32'd1};

  localparam int IDX_OVF = 0;

  // Tuned table for the 10x11 datapath, otherwise th[j] = 2^(NUM_TH-j)-1.
  function automatic logic [31:0] th_reset_val(input int num_th, input int cmp_w, input int j);
    logic [31:0] v;
    if (num_th == NUM_TH_DEF && cmp_w == CMP_W_DEF) begin
      v = TH_DEFAULT[j[3:0]];
    end else begin
      v = (32'd1 << (num_th - j)) - 32'd1;
    end
    if (cmp_w < 32) begin
      v = v & ((32'd1 << cmp_w) - 32'd1);
    end
    return v;
  endfunction

endpackage

// File: rtl/exp_idx_sel_pipe_if.sv
// Operand/result handshake and threshold config port of the range-index selector.
// out_ovf exists only when EXP_IDX_SEL_OVF_EN is defined.
interface exp_idx_sel_pipe_if #(
  parameter int DATA_W = 15,
  parameter int CMP_W  = 11,
  parameter int IDX_W  = 5,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
`ifdef EXP_IDX_SEL_OVF_EN
  logic              out_ovf;
`endif
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CMP_W-1:0]  cfg_wdata;
  logic [CMP_W-1:0]  cfg_rdata;
  logic              cfg_order_err;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
`ifdef EXP_IDX_SEL_OVF_EN
    input  out_ovf,
`endif
    input  in_ready, out_valid, out_idx, cfg_rdata, cfg_order_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
`ifdef EXP_IDX_SEL_OVF_EN
    output out_ovf,
`endif
    output in_ready, out_valid, out_idx, cfg_rdata, cfg_order_err
  );
endinterface

// File: rtl/exp_idx_sel_pipe_penc.sv
// Priority encoder: lowest set bit j yields j+1; an all-zero vector yields NUM_TH+1.
module exp_idx_penc #(
  parameter int NUM_TH = 10,
  parameter int IDX_W  = 5
) (
  input  logic [NUM_TH-1:0] vec_i,
  output logic [IDX_W-1:0]  idx_o
);

  always_comb begin
    idx_o = IDX_W'(NUM_TH + 1);
    for (int j = NUM_TH - 1; j >= 0; j--) begin
      if (vec_i[j]) idx_o = IDX_W'(j + 1);
    end
  end

endmodule

// File: rtl/exp_idx_sel_pipe.sv
// Two-stage range-index selector: stage 1 compares against the threshold table,
// stage 2 priority-encodes. Optional EXP_IDX_SEL_OVF_EN flags nonzero upper bits.
// rst_n asserts asynchronously; its release is expected to be synchronised upstream.
module exp_idx_sel_pipe
  import exp_sel_pkg::*;
#(
  parameter int DATA_W = 15,
  parameter int CMP_W  = 11,
  parameter int NUM_TH = 10,
  parameter int IDX_W  = 5,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  exp_idx_sel_pipe_if.slave bus
);

  logic [CMP_W-1:0]  th_q [NUM_TH];
  logic [CMP_W-1:0]  th_d [NUM_TH];
  logic              s1_valid_q, s1_valid_d;
  logic [NUM_TH-1:0] cmp_q, cmp_d, cmp_new;
  logic              out_valid_q, out_valid_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d, penc_idx;
  logic              order_err_q, order_err_d;
  logic [NUM_TH-2:0] ord_bad;
  logic              adv1, adv2;
  logic [CMP_W-1:0]  op_lo;
  logic [CMP_W-1:0]  rdata;

  assign op_lo = bus.in_data[CMP_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TH; gi++) begin : g_cmp
      assign cmp_new[gi] = op_lo > th_q[gi];
    end
    for (gi = 0; gi < NUM_TH - 1; gi++) begin : g_ord
      assign ord_bad[gi] = th_q[gi] <= th_q[gi+1];
    end
  endgenerate

  assign order_err_d = |ord_bad;

`ifdef EXP_IDX_SEL_OVF_EN
  logic ovf_q, ovf_d, out_ovf_q, out_ovf_d, ovf_new;
  generate
    if (DATA_W > CMP_W) begin : g_ovf
      assign ovf_new = |bus.in_data[DATA_W-1:CMP_W];
    end else begin : g_no_ovf
      assign ovf_new = 1'b0;
    end
  endgenerate
`else
  generate
    if (DATA_W > CMP_W) begin : g_hi_ignored
      logic unused_hi;
      assign unused_hi = ^bus.in_data[DATA_W-1:CMP_W];
    end
  endgenerate
`endif

  exp_idx_penc #(
    .NUM_TH (NUM_TH),
    .IDX_W  (IDX_W)
  ) u_penc (
    .vec_i (cmp_q),
    .idx_o (penc_idx)
  );

  // in_ready depends only on registered state and out_ready.
  always_comb begin
    adv2        = !out_valid_q || bus.out_ready;
    adv1        = !s1_valid_q || adv2;
    s1_valid_d  = s1_valid_q;
    cmp_d       = cmp_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
`ifdef EXP_IDX_SEL_OVF_EN
    ovf_d       = ovf_q;
    out_ovf_d   = out_ovf_q;
`endif
    if (adv1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        cmp_d = cmp_new;
`ifdef EXP_IDX_SEL_OVF_EN
        ovf_d = ovf_new;
`endif
      end
    end
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_idx_d = penc_idx;
`ifdef EXP_IDX_SEL_OVF_EN
        if (ovf_q) out_idx_d = IDX_W'(IDX_OVF);
        out_ovf_d = ovf_q;
`endif
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_TH; j++) begin
      th_d[j] = th_q[j];
    end
    if (bus.cfg_we) begin
      for (int j = 0; j < NUM_TH; j++) begin
        if (bus.cfg_addr == ADDR_W'(j)) th_d[j] = bus.cfg_wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < NUM_TH; j++) begin
      if (bus.cfg_addr == ADDR_W'(j)) rdata = th_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_TH; j++) begin
        th_q[j] <= CMP_W'(th_reset_val(NUM_TH, CMP_W, j));
      end
      s1_valid_q  <= 1'b0;
      cmp_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      order_err_q <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_TH; j++) begin
        th_q[j] <= th_d[j];
      end
      s1_valid_q  <= s1_valid_d;
      cmp_q       <= cmp_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      order_err_q <= order_err_d;
    end
  end

`ifdef EXP_IDX_SEL_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  assign bus.out_ovf = out_ovf_q;
`endif

  assign bus.in_ready      = adv1;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_idx       = out_idx_q;
  assign bus.cfg_rdata     = rdata;
  assign bus.cfg_order_err = order_err_q;

endmodule

// File: tb/tb_exp_idx_sel_pipe.sv
// Directed bench for exp_idx_sel_pipe: streaming, backpressure, config writes,
// order flag, overflow code (EXP_IDX_SEL_OVF_EN) and mid-flight reset.
module tb_exp_idx_sel_pipe;

  localparam int DATA_W = 15;
  localparam int CMP_W  = 11;
  localparam int NUM_TH = 10;
  localparam int IDX_W  = 5;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   stim_q [16];
  int   exp_q  [16];
  int   first_cyc, last_cyc, rd;

  always #5 clk = ~clk;

  exp_idx_sel_pipe_if #(
    .DATA_W (DATA_W), .CMP_W (CMP_W), .IDX_W (IDX_W), .ADDR_W (ADDR_W)
  ) bus_if ();

  exp_idx_sel_pipe #(
    .DATA_W (DATA_W), .CMP_W (CMP_W), .NUM_TH (NUM_TH), .IDX_W (IDX_W), .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int data);
    bus_if.cfg_we    = 1'b1;
    bus_if.cfg_addr  = ADDR_W'(addr);
    bus_if.cfg_wdata = CMP_W'(data);
    tick();
    bus_if.cfg_we    = 1'b0;
  endtask

  task automatic rd_th(input int addr, output int v);
    bus_if.cfg_addr = ADDR_W'(addr);
    #1;
    v = int'(bus_if.cfg_rdata);
  endtask

  // Feeds stim_q[0..n-1]; out_ready held low for the first 'stall' cycles.
  task automatic run_stream(input int n, input int stall, output int fc, output int lc);
    int ii = 0;
    int oi = 0;
    int cyc = 0;
    fc = -1;
    lc = -1;
    while (oi < n && cyc < 60) begin
      bus_if.out_ready = (cyc >= stall);
      bus_if.in_valid  = (ii < n);
      bus_if.in_data   = (ii < n) ? DATA_W'(stim_q[ii]) : '0;
      #1;
      if (cyc < stall && cyc >= 2) begin
        check($sformatf("stall c%0d in_ready", cyc), bus_if.in_ready, 0);
        check($sformatf("stall c%0d out_valid", cyc), bus_if.out_valid, 1);
        check($sformatf("stall c%0d out_idx", cyc), bus_if.out_idx, exp_q[0]);
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        check($sformatf("out_idx[%0d] (in %0d)", oi, stim_q[oi]), bus_if.out_idx, exp_q[oi]);
        if (fc < 0) fc = cyc;
        lc = cyc;
        oi++;
      end
      if (bus_if.in_valid && bus_if.in_ready) ii++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    check("stream results count", oi, n);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b1;
    bus_if.cfg_we    = 1'b0;
    bus_if.cfg_addr  = '0;
    bus_if.cfg_wdata = '0;
    tick();
    tick();

    // Reset state and default table
    check("rst out_valid", bus_if.out_valid, 0);
    check("rst out_idx", bus_if.out_idx, 0);
    check("rst order_err", bus_if.cfg_order_err, 0);
    rd_th(0, rd); check("rst th[0]", rd, 830);
    rd_th(9, rd); check("rst th[9]", rd, 1);
    rst_n = 1'b1;
    tick();

    // Back-to-back stream, no backpressure
    stim_q[0:5] = '{1024, 831, 830, 2, 1, 0};
    exp_q[0:5]  = '{1, 1, 2, 10, 11, 11};
    run_stream(6, 0, first_cyc, last_cyc);
    check("latency first out cycle", first_cyc, 2);
    check("consecutive outputs span", last_cyc - first_cyc, 5);

    // Backpressure: 4 stalled cycles with a continuous stream
    stim_q[0:5] = '{1024, 500, 300, 100, 50, 8};
    exp_q[0:5]  = '{1, 2, 3, 5, 6, 8};
    run_stream(6, 4, first_cyc, last_cyc);
    check("stall first out cycle", first_cyc, 4);

    // Config write coinciding with acceptance uses the old threshold
    bus_if.out_ready = 1'b1;
    bus_if.cfg_we    = 1'b1;
    bus_if.cfg_addr  = 4'd0;
    bus_if.cfg_wdata = CMP_W'(1000);
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = DATA_W'(900);
    #1;
    check("in_ready during cfg write", bus_if.in_ready, 1);
    tick();
    bus_if.cfg_we = 1'b0;
    tick();
    bus_if.in_valid = 1'b0;
    check("900 old th valid", bus_if.out_valid, 1);
    check("900 old th idx", bus_if.out_idx, 1);
    tick();
    check("900 new th valid", bus_if.out_valid, 1);
    check("900 new th idx", bus_if.out_idx, 2);
    rd_th(0, rd); check("th[0] after write", rd, 1000);
    tick();
    check("pipe empty after pair", bus_if.out_valid, 0);
    cfg_write(0, 830);

    // Order flag and out-of-range writes
    cfg_write(3, 300);
    check("order_err same cycle", bus_if.cfg_order_err, 0);
    tick();
    check("order_err set", bus_if.cfg_order_err, 1);
    rd_th(3, rd); check("th[3] = 300", rd, 300);
    cfg_write(3, 124);
    tick();
    check("order_err cleared", bus_if.cfg_order_err, 0);
    rd_th(3, rd); check("th[3] = 124", rd, 124);
    cfg_write(12, 5);
    rd_th(12, rd); check("rdata addr 12", rd, 0);
    rd_th(9, rd); check("th[9] after addr 12 write", rd, 1);
    tick();
    check("order_err after addr 12 write", bus_if.cfg_order_err, 0);

    // Upper operand bits
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 15'h0800;
    tick();
    bus_if.in_data  = 15'h07FF;
    tick();
    bus_if.in_valid = 1'b0;
    check("hi-bit op valid", bus_if.out_valid, 1);
`ifdef EXP_IDX_SEL_OVF_EN
    check("hi-bit op idx", bus_if.out_idx, 0);
    check("hi-bit op ovf", bus_if.out_ovf, 1);
`else
    check("hi-bit op idx", bus_if.out_idx, 11);
`endif
    tick();
    check("7FF idx", bus_if.out_idx, 1);
`ifdef EXP_IDX_SEL_OVF_EN
    check("7FF ovf", bus_if.out_ovf, 0);
`endif
    tick();

    // Reset with two operands in flight and a disordered table
    cfg_write(0, 1000);
    cfg_write(5, 500);
    tick();
    check("pre-reset order_err", bus_if.cfg_order_err, 1);
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = DATA_W'(1024);
    tick();
    bus_if.in_data   = DATA_W'(831);
    tick();
    bus_if.in_valid  = 1'b0;
    check("pre-reset out_valid", bus_if.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset out_valid", bus_if.out_valid, 0);
    check("reset out_idx", bus_if.out_idx, 0);
    check("reset order_err", bus_if.cfg_order_err, 0);
    rd_th(0, rd); check("reset th[0]", rd, 830);
    rd_th(5, rd); check("reset th[5]", rd, 31);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post-reset c%0d out_valid", k), bus_if.out_valid, 0);
    end
    stim_q[0] = 831;
    exp_q[0]  = 1;
    run_stream(1, 0, first_cyc, last_cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
